// File: rtl/ahbl_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_sram_slave
// Description : AHB-Lite responder in front of a single-port synchronous SRAM
//               macro with byte write enables and registered read data.
//               Aligned transfers complete with zero wait states. Write data
//               (AHB data phase) lands in a one-entry write buffer. The buffer
//               is committed to the SRAM in the next cycle that is not a read
//               address phase, so reads never contend with writes for the
//               port. Reads that hit the buffered word get the buffered bytes
//               merged in. Illegal or misaligned transfers receive a two-cycle
//               ERROR response and never reach the SRAM.
// Ports       : HCLK, HRESET             clock, synchronous active-high reset
//               HSEL, HADDR, HTRANS,
//               HWRITE, HSIZE, HWDATA,
//               HREADY                   AHB-Lite slave inputs
//               HREADYOUT, HRESP, HRDATA AHB-Lite slave outputs
//               SRAMRDATA                SRAM read data (one cycle after read)
//               SRAMCS, SRAMWEN,
//               SRAMADDR, SRAMWDATA      SRAM control / address / write data
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_sram_slave #(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS,
    output logic [AW-1:0] SRAMADDR
);

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_hreadyout;
    logic          r_hresp;

    logic          r_rd_pend;
    logic [AW-1:0] r_rd_addr;
    logic          r_wr_pend;
    logic [AW-1:0] r_wr_addr;
    logic [3:0]    r_wr_lanes;

    logic          r_buf_valid;
    logic [AW-1:0] r_buf_addr;
    logic [3:0]    r_buf_lanes;
    logic [31:0]   r_buf_data;

    logic          w_valid;
    logic          w_illegal;
    logic          w_err_req;
    logic          w_legal_rd;
    logic          w_legal_wr;
    logic          w_commit;
    logic          w_fwd_hit;
    logic [3:0]    w_lanes;
    logic [AW-1:0] w_word_addr;
    logic          w_unused;

    // Address bits above the SRAM window alias; HTRANS[0] only separates
    // NONSEQ from SEQ, which this slave treats identically.
    assign w_unused    = ^{HADDR[31:AW+2], HTRANS[0]};

    assign w_valid     = HSEL & HREADY & HTRANS[1];
    assign w_illegal   = (HSIZE > 3'd2)
                       | ((HSIZE == 3'd1) & HADDR[0])
                       | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign w_err_req   = w_valid & w_illegal;
    assign w_word_addr = HADDR[AW+1:2];

    // Reset also blocks SRAM activity in the reset cycle itself, so a
    // buffered write can never slip out while reset is asserted.
    assign w_legal_rd  = w_valid & ~w_illegal & ~HWRITE & ~HRESET;
    assign w_legal_wr  = w_valid & ~w_illegal &  HWRITE & ~HRESET;

    // The buffer drains in any cycle the port is not claimed by a read.
    assign w_commit    = r_buf_valid & ~w_legal_rd & ~HRESET;

    always_comb begin
        w_lanes = 4'b1111;
        case (HSIZE)
            3'd0:    w_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    // SRAM port: the read address phase has priority over the commit.
    assign SRAMCS    = w_legal_rd | w_commit;
    assign SRAMWEN   = w_commit ? r_buf_lanes : 4'b0000;
    assign SRAMADDR  = w_legal_rd ? w_word_addr : r_buf_addr;
    assign SRAMWDATA = r_buf_data;

    // Read data phase: buffered bytes override the (possibly stale) SRAM
    // bytes when the buffer holds the word being read.
    assign w_fwd_hit = r_buf_valid & (r_buf_addr == r_rd_addr);

    always_comb begin
        HRDATA = 32'h0;
        if (r_rd_pend) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = (w_fwd_hit && r_buf_lanes[i])
                                 ? r_buf_data[8*i +: 8]
                                 : SRAMRDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

    // Control state and the ERROR-response FSM.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_OKAY;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_buf_valid <= 1'b0;
        end else begin
            r_rd_pend <= w_legal_rd;
            r_wr_pend <= w_legal_wr;

            // A refill in the same cycle as a commit keeps the buffer full.
            if (r_wr_pend) begin
                r_buf_valid <= 1'b1;
            end else if (w_commit) begin
                r_buf_valid <= 1'b0;
            end

            case (r_state)
                ST_OKAY: begin
                    if (w_err_req) begin
                        r_state     <= ST_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                    end else begin
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                ST_ERR2: begin
                    if (w_err_req) begin
                        r_state     <= ST_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                    end else begin
                        r_state     <= ST_OKAY;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_OKAY;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // Address/data capture; these are qualified by the pending/valid flags
    // above and need no reset.
    always_ff @(posedge HCLK) begin
        if (w_legal_rd) begin
            r_rd_addr <= w_word_addr;
        end
        if (w_legal_wr) begin
            r_wr_addr  <= w_word_addr;
            r_wr_lanes <= w_lanes;
        end
        if (r_wr_pend) begin
            r_buf_addr  <= r_wr_addr;
            r_buf_lanes <= r_wr_lanes;
            for (int i = 0; i < 4; i++) begin
                if (r_wr_lanes[i]) begin
                    r_buf_data[8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahbl_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_sram_slave
// Description : Self-checking bench for ahbl_sram_slave. Holds a byte-level
//               memory image that reflects every accepted AHB write, plus an
//               SRAM macro model connected to the DUT pins. Directed scenarios
//               are followed by randomized traffic and a final comparison of
//               the SRAM contents against the memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_sram_slave;

    localparam int AW     = 8;
    localparam int NWORDS = 2 ** AW;

    localparam logic [1:0] c_idle   = 2'b00;
    localparam logic [1:0] c_busy   = 2'b01;
    localparam logic [1:0] c_nonseq = 2'b10;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   SRAMRDATA;
    logic [3:0]    SRAMWEN;
    logic [31:0]   SRAMWDATA;
    logic          SRAMCS;
    logic [AW-1:0] SRAMADDR;

    always #5 HCLK = ~HCLK;

    ahbl_sram_slave #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS    (SRAMCS),
        .SRAMADDR  (SRAMADDR)
    );

    // SRAM macro model with a backdoor preload port.
    logic [31:0]   sram [0:NWORDS-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    always @(posedge HCLK) begin
        if (SRAMCS) begin
            if (|SRAMWEN) begin
                for (int b = 0; b < 4; b++) begin
                    if (SRAMWEN[b]) sram[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
                end
            end else begin
                SRAMRDATA <= sram[SRAMADDR];
            end
        end
        if (pl_en) sram[pl_addr] <= pl_data;
    end

    // Reference state: memory image as seen by the bus master.
    logic [7:0]    ref_mem [0:4*NWORDS-1];
    int            checks = 0;
    int            errors = 0;
    int            err_phase = 0;     // 0: OKAY, 1: first ERROR cycle, 2: second
    bit            prev_rd = 0;
    logic [AW-1:0] prev_rd_addr = '0;
    bit            prev_wr = 0;
    logic [AW-1:0] prev_wr_addr = '0;
    logic [3:0]    prev_wr_lanes = '0;
    logic [31:0]   next_wdata = '0;
    bit            outstanding = 0;   // accepted write not yet seen at the SRAM

    logic          s_cs, s_ready, s_resp;
    logic [3:0]    s_wen;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata, s_rdata;

    function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
        int i;
        i = int'(a) * 4;
        return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endfunction

    function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [31:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        if (size == 3'd0) return 4'b0001 << lo;
        if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive address phase (and data phase of the previous
    // write), check outputs mid-cycle, advance the reference state.
    task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] data, input logic rst);
        bit            v, ill, lg;
        logic [AW-1:0] wa;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HWDATA = next_wdata;
        HREADY = (err_phase != 1);
        HRESET = rst;
        v   = sel && HREADY && trans[1];
        ill = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
        lg  = v && !ill && !rst;
        wa  = addr[AW+1:2];
        #4;
        s_cs = SRAMCS; s_wen = SRAMWEN; s_addr = SRAMADDR; s_wdata = SRAMWDATA;
        s_rdata = HRDATA; s_ready = HREADYOUT; s_resp = HRESP;
        if (rst) begin
            chk("rst_cycle_cs", {31'b0, s_cs}, 32'd0);
            chk("rst_cycle_wen", {28'b0, s_wen}, 32'd0);
        end else begin
            chk("hreadyout", {31'b0, s_ready}, {31'b0, err_phase != 1});
            chk("hresp", {31'b0, s_resp}, {31'b0, err_phase != 0});
            chk("hrdata", s_rdata, prev_rd ? ref_word(prev_rd_addr) : 32'h0);
            if (lg && !wr) begin
                chk("rd_cs", {31'b0, s_cs}, 32'd1);
                chk("rd_wen", {28'b0, s_wen}, 32'd0);
                chk("rd_addr", {{(32-AW){1'b0}}, s_addr}, {{(32-AW){1'b0}}, wa});
            end
            if (s_cs && s_wen != 4'b0) begin
                chk("no_spurious_write", {31'b0, outstanding}, 32'd1);
                outstanding = 0;
            end
            if (prev_wr) begin
                // A refill must never find an uncommitted write in the buffer.
                chk("invariant_drained", {31'b0, outstanding}, 32'd0);
                for (int b = 0; b < 4; b++) begin
                    if (prev_wr_lanes[b]) ref_mem[int'(prev_wr_addr)*4 + b] = HWDATA[8*b +: 8];
                end
                outstanding = 1;
            end
        end
        @(posedge HCLK);
        #1;
        if (rst) begin
            prev_rd = 0; prev_wr = 0; outstanding = 0; err_phase = 0; next_wdata = '0;
        end else begin
            prev_rd       = lg && !wr;
            prev_rd_addr  = wa;
            prev_wr       = lg && wr;
            prev_wr_addr  = wa;
            prev_wr_lanes = lanes_of(size, addr);
            err_phase     = (v && ill) ? 1 : ((err_phase == 1) ? 2 : 0);
            next_wdata    = data;
        end
    endtask

    task automatic idle();
        xfer(1'b0, c_idle, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    // Backdoor load of one SRAM word; only used while no write is buffered.
    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        for (int b = 0; b < 4; b++) ref_mem[int'(a)*4 + b] = d[8*b +: 8];
        idle();
        pl_en = 1'b0;
    endtask

    initial begin
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = c_idle; HWRITE = 1'b0;
        HSIZE = 3'd0; HWDATA = '0; HREADY = 1'b1;
        @(posedge HCLK);
        #1;
        xfer(1'b0, c_idle, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        xfer(1'b0, c_idle, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

        // Reset state.
        idle();
        chk("reset_hreadyout", {31'b0, s_ready}, 32'd1);
        chk("reset_hresp", {31'b0, s_resp}, 32'd0);
        chk("reset_hrdata", s_rdata, 32'h0);
        chk("reset_sramcs", {31'b0, s_cs}, 32'd0);

        for (int w = 0; w < NWORDS; w++) preload(w[AW-1:0], $urandom);

        // Word write, then idle: commit in the cycle after the data phase.
        xfer(1'b1, c_nonseq, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
        idle();
        chk("t1_dataphase_cs", {31'b0, s_cs}, 32'd0);
        idle();
        chk("t1_cs", {31'b0, s_cs}, 32'd1);
        chk("t1_wen", {28'b0, s_wen}, 32'hF);
        chk("t1_addr", {{(32-AW){1'b0}}, s_addr}, 32'd4);
        chk("t1_wdata", s_wdata, 32'hDEADBEEF);
        chk("t1_ready", {31'b0, s_ready}, 32'd1);
        idle();

        // Byte write followed immediately by a word read of the same word.
        preload(4, 32'h11223344);
        xfer(1'b1, c_nonseq, 1'b1, 3'd0, 32'h13, 32'hAA000000, 1'b0);
        xfer(1'b1, c_nonseq, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
        chk("t2_read_wen", {28'b0, s_wen}, 32'd0);
        idle();
        chk("t2_fwd_hrdata", s_rdata, 32'hAA223344);
        chk("t2_commit_wen", {28'b0, s_wen}, 32'h8);
        chk("t2_commit_addr", {{(32-AW){1'b0}}, s_addr}, 32'd4);
        chk("t2_commit_byte", {24'b0, s_wdata[31:24]}, 32'hAA);
        idle();

        // Half write then three reads: buffer held across the reads.
        preload(8, 32'h00005678);
        xfer(1'b1, c_nonseq, 1'b1, 3'd1, 32'h22, 32'hBEEF0000, 1'b0);
        for (int r = 0; r < 3; r++) begin
            xfer(1'b1, c_nonseq, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
            chk("t3_read_wen", {28'b0, s_wen}, 32'd0);
            if (r > 0) chk("t3_fwd_hrdata", s_rdata, 32'hBEEF5678);
        end
        idle();
        chk("t3_last_hrdata", s_rdata, 32'hBEEF5678);
        chk("t3_commit_wen", {28'b0, s_wen}, 32'hC);
        chk("t3_commit_addr", {{(32-AW){1'b0}}, s_addr}, 32'd8);
        idle();

        // Misaligned word read and HSIZE=3: two-cycle ERROR, no SRAM access.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) xfer(1'b1, c_nonseq, 1'b0, 3'd2, 32'h02, 32'h0, 1'b0);
            else        xfer(1'b1, c_nonseq, 1'b0, 3'd3, 32'h20, 32'h0, 1'b0);
            chk("t4_addr_cs", {31'b0, s_cs}, 32'd0);
            idle();
            chk("t4_err1_ready", {31'b0, s_ready}, 32'd0);
            chk("t4_err1_resp", {31'b0, s_resp}, 32'd1);
            chk("t4_err1_cs", {31'b0, s_cs}, 32'd0);
            idle();
            chk("t4_err2_ready", {31'b0, s_ready}, 32'd1);
            chk("t4_err2_resp", {31'b0, s_resp}, 32'd1);
            chk("t4_err2_cs", {31'b0, s_cs}, 32'd0);
            idle();
            chk("t4_okay_resp", {31'b0, s_resp}, 32'd0);
        end

        // BUSY and deselected NONSEQ: no access, OKAY, zero wait.
        xfer(1'b1, c_busy, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
        chk("t5_busy_cs", {31'b0, s_cs}, 32'd0);
        xfer(1'b0, c_nonseq, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
        chk("t5_nosel_cs", {31'b0, s_cs}, 32'd0);
        idle();
        chk("t5_hrdata", s_rdata, 32'h0);
        chk("t5_ready", {31'b0, s_ready}, 32'd1);
        chk("t5_resp", {31'b0, s_resp}, 32'd0);

        // Reset during the buffer-fill cycle discards the write.
        xfer(1'b1, c_nonseq, 1'b1, 3'd2, 32'h40, 32'h12345678, 1'b0);
        xfer(1'b0, c_idle, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("t6_ready", {31'b0, s_ready}, 32'd1);
            chk("t6_resp", {31'b0, s_resp}, 32'd0);
            chk("t6_hrdata", s_rdata, 32'h0);
            chk("t6_cs", {31'b0, s_cs}, 32'd0);
            chk("t6_wen", {28'b0, s_wen}, 32'd0);
        end
        xfer(1'b1, c_nonseq, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
        idle();

        // Randomized traffic over a small window with aliased high bits.
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic [2:0]  sz;
            r  = $urandom_range(0, 9);
            sz = (r == 9) ? 3'd3 : 3'(r % 3);
            xfer($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 sz, ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31)), $urandom, 1'b0);
        end
        for (int k = 0; k < 4; k++) idle();
        chk("drained", {31'b0, outstanding}, 32'd0);
        for (int w = 0; w < 8; w++) chk("final_mem", sram[w], ref_word(w[AW-1:0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
